// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM state encoding,
// condition-code field values, instruction class values, ALU opcodes and
// the NZCV bit positions used by both the controller and cond_check.
package ctrl_pkg;

  // Controller states; the numeric values are visible on state_o
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  // Condition field encodings (instruction bits 31:28)
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Instruction class encodings (instruction bits 27:26)
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // ALU opcodes driven on alu_ctrl
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;

  // Bit positions inside an NZCV nibble
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // TST/TEQ/CMP/CMN share opcode[3:2]=10: they only update flags
  function automatic logic is_test_op(input logic [1:0] opcode_hi);
    return (opcode_hi == 2'b10);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_cond_check.sv
// Combinational evaluation of an instruction condition field against the
// stored NZCV flags. pass=1 means the instruction should execute.
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n_flag;
  logic z_flag;
  logic c_flag;
  logic v_flag;

  assign n_flag = flags[FLAG_N];
  assign z_flag = flags[FLAG_Z];
  assign c_flag = flags[FLAG_C];
  assign v_flag = flags[FLAG_V];

  // Decode the condition mnemonic into a pass/fail on the current flags
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z_flag;
      COND_NE: pass = ~z_flag;
      COND_CS: pass = c_flag;
      COND_CC: pass = ~c_flag;
      COND_MI: pass = n_flag;
      COND_PL: pass = ~n_flag;
      COND_VS: pass = v_flag;
      COND_VC: pass = ~v_flag;
      COND_HI: pass = c_flag & ~z_flag;
      COND_LS: pass = ~c_flag | z_flag;
      COND_GE: pass = (n_flag == v_flag);
      COND_LT: pass = (n_flag != v_flag);
      COND_GT: pass = ~z_flag & (n_flag == v_flag);
      COND_LE: pass = z_flag | (n_flag != v_flag);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for a small ARM-like datapath. Sequences fetch,
// decode, data-processing, load/store and branch instructions and keeps
// the architectural NZCV flags.
//
// Optional feature: define MULTICYCLE_CTRL_MEM_WAIT_EN to make FETCH, MEMRD
// and MEMWR wait for mem_ready. Without it every memory access completes
// in a single cycle and mem_ready is ignored.
//
// Datapath strobes are decoded combinationally from the current state and
// the instruction fields so FETCH can raise ir_write/pc_write in the very
// cycle memory reports ready. They are forced low while rst_n is low so a
// reset abandons any access immediately.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic       i_bit,
  input  logic [3:0] opcode,
  input  logic       s_bit,
  input  logic       u_bit,
  input  logic       l1_bit,
  input  logic       l2_bit,
  input  logic [3:0] alu_nzcv,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       flags_write,
  output logic       link_sel,
  output logic       adr_src,
  output logic       alu_src_b,
  output logic [3:0] alu_ctrl,
  output logic [3:0] flags_q,
  output logic [3:0] state_o
);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] flags_d;
  logic       cond_pass;
  logic       mem_done;
  logic       test_op;

  logic pc_write_raw;
  logic ir_write_raw;
  logic reg_write_raw;
  logic mem_read_raw;
  logic mem_write_raw;
  logic flags_write_raw;
  logic link_sel_raw;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  assign mem_done = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_done         = 1'b1;
`endif

  assign test_op = is_test_op(opcode[3:2]);
  assign state_o = state_q;

  cond_check u_cond_check (
    .cond  (cond),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  // Next-state sequencing and the flag register update
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    case (state_q)
      S_FETCH: begin
        if (mem_done) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!cond_pass) begin
          state_d = S_FETCH;
        end else begin
          case (op)
            OP_DP:   state_d = i_bit ? S_EXECI : S_EXECR;
            OP_MEM:  state_d = S_MEMADR;
            OP_BR:   state_d = S_BRANCH;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_MEMADR: state_d = l1_bit ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_done) state_d = S_MEMWB;
      end
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR: begin
        if (mem_done) state_d = S_FETCH;
      end
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
    if (flags_write_raw) flags_d = alu_nzcv;
  end

  // Moore decode of datapath controls from the current state and fields
  always_comb begin
    pc_write_raw    = 1'b0;
    ir_write_raw    = 1'b0;
    reg_write_raw   = 1'b0;
    mem_read_raw    = 1'b0;
    mem_write_raw   = 1'b0;
    flags_write_raw = 1'b0;
    link_sel_raw    = 1'b0;
    adr_src         = 1'b0;
    alu_src_b       = 1'b0;
    alu_ctrl        = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read_raw = 1'b1;
        ir_write_raw = mem_done;
        pc_write_raw = mem_done;
      end
      S_EXECR: begin
        alu_ctrl = opcode;
      end
      S_EXECI: begin
        alu_ctrl  = opcode;
        alu_src_b = 1'b1;
      end
      S_ALUWB: begin
        reg_write_raw   = ~test_op;
        flags_write_raw = s_bit | test_op;
      end
      S_MEMADR: begin
        alu_ctrl  = u_bit ? ALU_ADD : ALU_SUB;
        alu_src_b = 1'b1;
      end
      S_MEMRD: begin
        mem_read_raw = 1'b1;
        adr_src      = 1'b1;
      end
      S_MEMWB: begin
        reg_write_raw = 1'b1;
      end
      S_MEMWR: begin
        mem_write_raw = 1'b1;
        adr_src       = 1'b1;
      end
      S_BRANCH: begin
        pc_write_raw  = 1'b1;
        alu_ctrl      = ALU_ADD;
        alu_src_b     = 1'b1;
        reg_write_raw = l2_bit;
        link_sel_raw  = l2_bit;
      end
      default: begin
        alu_ctrl = ALU_ADD;
      end
    endcase
  end

  assign pc_write    = pc_write_raw    & rst_n;
  assign ir_write    = ir_write_raw    & rst_n;
  assign reg_write   = reg_write_raw   & rst_n;
  assign mem_read    = mem_read_raw    & rst_n;
  assign mem_write   = mem_write_raw   & rst_n;
  assign flags_write = flags_write_raw & rst_n;
  assign link_sel    = link_sel_raw    & rst_n;

  // State and flag registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. A per-instruction reference model
// builds the expected cycle-by-cycle trace (state, strobes, stored flags)
// from the instruction fields, the current flags and the chosen memory
// stall counts; the bench replays it and compares what the DUT shows.
module tb_multicycle_ctrl;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cond;
  logic [1:0] op;
  logic       i_bit;
  logic [3:0] opcode;
  logic       s_bit;
  logic       u_bit;
  logic       l1_bit;
  logic       l2_bit;
  logic [3:0] alu_nzcv;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       flags_write;
  logic       link_sel;
  logic       adr_src;
  logic       alu_src_b;
  logic [3:0] alu_ctrl;
  logic [3:0] flags_q;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cond        (cond),
    .op          (op),
    .i_bit       (i_bit),
    .opcode      (opcode),
    .s_bit       (s_bit),
    .u_bit       (u_bit),
    .l1_bit      (l1_bit),
    .l2_bit      (l2_bit),
    .alu_nzcv    (alu_nzcv),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .flags_write (flags_write),
    .link_sel    (link_sel),
    .adr_src     (adr_src),
    .alu_src_b   (alu_src_b),
    .alu_ctrl    (alu_ctrl),
    .flags_q     (flags_q),
    .state_o     (state_o)
  );

  typedef struct packed {
    logic [3:0] state;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       flags_write;
    logic       link_sel;
    logic       adr_src;
    logic       alu_src_b;
    logic [3:0] alu_ctrl;
    logic [3:0] flags;
  } cyc_t;

  cyc_t       exp_q[$];
  cyc_t       obs_q[$];
  bit         rdy_q[$];
  logic [3:0] model_flags;
  int         checks = 0;
  int         passed = 0;

  // Architectural condition rules on an NZCV nibble
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // A cycle with nothing asserted, ALU defaulting to ADD
  function automatic cyc_t quiet(input logic [3:0] st);
    cyc_t c;
    c = '0;
    c.state    = st;
    c.alu_ctrl = 4'b0100;
    c.flags    = model_flags;
    return c;
  endfunction

  // A memory access: stalls cycles without ready when waiting is built in
  task automatic push_mem(input cyc_t c, input int stalls);
    if (WAIT_EN) begin
      for (int k = 0; k < stalls; k++) begin
        exp_q.push_back(c);
        rdy_q.push_back(1'b0);
      end
      exp_q.push_back(c);
      rdy_q.push_back(1'b1);
    end else begin
      exp_q.push_back(c);
      rdy_q.push_back(1'($urandom_range(0, 1)));
    end
  endtask

  // Expected trace of one whole instruction from FETCH onward
  task automatic build_trace(input int stall_f, input int stall_m);
    cyc_t c;
    bit   is_test;
    exp_q.delete();
    rdy_q.delete();
    c = quiet(4'd0);
    c.mem_read = 1'b1;
    if (WAIT_EN) begin
      for (int k = 0; k < stall_f; k++) begin
        exp_q.push_back(c);
        rdy_q.push_back(1'b0);
      end
    end
    c.ir_write = 1'b1;
    c.pc_write = 1'b1;
    exp_q.push_back(c);
    rdy_q.push_back(WAIT_EN ? 1'b1 : 1'($urandom_range(0, 1)));
    exp_q.push_back(quiet(4'd1));
    rdy_q.push_back(1'($urandom_range(0, 1)));
    if (!cond_holds(cond, model_flags) || op == 2'b11) return;
    case (op)
      2'b00: begin
        c = quiet(i_bit ? 4'd7 : 4'd6);
        c.alu_ctrl  = opcode;
        c.alu_src_b = i_bit;
        exp_q.push_back(c);
        rdy_q.push_back(1'b0);
        is_test = (opcode >= 4'd8 && opcode <= 4'd11);
        c = quiet(4'd8);
        c.reg_write   = !is_test;
        c.flags_write = s_bit || is_test;
        exp_q.push_back(c);
        rdy_q.push_back(1'b0);
        if (c.flags_write) model_flags = alu_nzcv;
      end
      2'b01: begin
        c = quiet(4'd2);
        c.alu_ctrl  = u_bit ? 4'b0100 : 4'b0010;
        c.alu_src_b = 1'b1;
        exp_q.push_back(c);
        rdy_q.push_back(1'b0);
        if (l1_bit) begin
          c = quiet(4'd3);
          c.mem_read = 1'b1;
          c.adr_src  = 1'b1;
          push_mem(c, stall_m);
          c = quiet(4'd4);
          c.reg_write = 1'b1;
          exp_q.push_back(c);
          rdy_q.push_back(1'b0);
        end else begin
          c = quiet(4'd5);
          c.mem_write = 1'b1;
          c.adr_src   = 1'b1;
          push_mem(c, stall_m);
        end
      end
      default: begin
        c = quiet(4'd9);
        c.pc_write  = 1'b1;
        c.alu_src_b = 1'b1;
        c.reg_write = l2_bit;
        c.link_sel  = l2_bit;
        exp_q.push_back(c);
        rdy_q.push_back(1'b0);
      end
    endcase
  endtask

  function automatic cyc_t sample_dut();
    cyc_t o;
    o.state       = state_o;
    o.mem_read    = mem_read;
    o.mem_write   = mem_write;
    o.ir_write    = ir_write;
    o.pc_write    = pc_write;
    o.reg_write   = reg_write;
    o.flags_write = flags_write;
    o.link_sel    = link_sel;
    o.adr_src     = adr_src;
    o.alu_src_b   = alu_src_b;
    o.alu_ctrl    = alu_ctrl;
    o.flags       = flags_q;
    return o;
  endfunction

  // Replay the expected trace length, recording what the DUT shows
  task automatic drive_trace();
    obs_q.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      mem_ready = rdy_q[i];
      #1;
      obs_q.push_back(sample_dut());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [3:0] c, input logic [1:0] o,
                            input logic ib, input logic [3:0] opc,
                            input logic sb, input logic ub, input logic l1,
                            input logic l2, input logic [3:0] nzcv);
    cond = c; op = o; i_bit = ib; opcode = opc; s_bit = sb;
    u_bit = ub; l1_bit = l1; l2_bit = l2; alu_nzcv = nzcv;
  endtask

  task automatic test_reset();
    logic [14:0] obs;
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    set_fields(4'($urandom), 2'($urandom), 1'($urandom), 4'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
    repeat (3) @(negedge clk);
    #1;
    obs = {state_o, flags_q, mem_read, mem_write, ir_write, pc_write,
           reg_write, flags_write, link_sel};
    checks++;
    if (obs !== 15'd0) $display("[TB] FAIL reset_state: got %h expected 0000", obs);
    else passed++;
    model_flags = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    set_fields(4'hE, 2'b00, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100);
    build_trace(0, 0);
    drive_trace();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        $display("[TB] FAIL add cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
    checks++;
    if (flags_q !== 4'b0100) $display("[TB] FAIL add_flags: got %b expected 0100", flags_q);
    else passed++;
  endtask

  task automatic test_beq_taken();
    set_fields(4'h0, 2'b10, 1'b0, 4'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 4'($urandom));
    build_trace(1, 0);
    drive_trace();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        $display("[TB] FAIL beq_taken cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_cmp();
    set_fields(4'hE, 2'b00, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    build_trace(0, 0);
    drive_trace();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        $display("[TB] FAIL cmp cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
    checks++;
    if (flags_q !== 4'b0000) $display("[TB] FAIL cmp_flags: got %b expected 0000", flags_q);
    else passed++;
  endtask

  task automatic test_beq_not_taken();
    set_fields(4'h0, 2'b10, 1'b0, 4'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, 4'($urandom));
    build_trace(0, 0);
    drive_trace();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        $display("[TB] FAIL beq_not_taken cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
    checks++;
    if (exp_q.size() != (WAIT_EN ? 2 : 2) || state_o !== 4'd0)
      $display("[TB] FAIL beq_not_taken_state: got %0d expected 0", state_o);
    else passed++;
  endtask

  task automatic test_ldr_wait();
    int rd_cycles;
    set_fields(4'hE, 2'b01, 1'b0, 4'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 4'($urandom));
    build_trace(2, 3);
    drive_trace();
    rd_cycles = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        $display("[TB] FAIL ldr cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      else passed++;
      if (obs_q[i].state == 4'd3 && obs_q[i].mem_read) rd_cycles++;
    end
    checks++;
    if (rd_cycles != (WAIT_EN ? 4 : 1))
      $display("[TB] FAIL ldr_memrd_len: got %0d expected %0d", rd_cycles, WAIT_EN ? 4 : 1);
    else passed++;
  endtask

  task automatic test_bl();
    set_fields(4'hE, 2'b10, 1'b0, 4'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, 4'($urandom));
    build_trace(0, 0);
    drive_trace();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        $display("[TB] FAIL bl cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_in_memwr();
    logic [14:0] obs;
    set_fields(4'hE, 2'b00, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011);
    build_trace(0, 0);
    drive_trace();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        $display("[TB] FAIL adds_pre cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
    set_fields(4'hE, 2'b01, 1'b0, 4'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 4'($urandom));
    build_trace(0, 2);
    while (exp_q.size() > 3) begin
      void'(exp_q.pop_back());
      void'(rdy_q.pop_back());
    end
    drive_trace();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        $display("[TB] FAIL str cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'd5) $display("[TB] FAIL str_in_memwr: got %0d expected 5", state_o);
    else passed++;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    obs = {state_o, flags_q, mem_read, mem_write, ir_write, pc_write,
           reg_write, flags_write, link_sel};
    checks++;
    if (obs !== 15'd0) $display("[TB] FAIL reset_from_memwr: got %h expected 0000", obs);
    else passed++;
    model_flags = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      set_fields(4'($urandom), 2'($urandom), 1'($urandom), 4'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
      if ($urandom_range(0, 3) != 0) cond = 4'hE;
      build_trace($urandom_range(0, 3), $urandom_range(0, 3));
      drive_trace();
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i])
          $display("[TB] FAIL random%0d cyc%0d: got %h expected %h", n, i, obs_q[i], exp_q[i]);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_beq_taken();
    test_cmp();
    test_beq_not_taken();
    test_ldr_wait();
    test_bl();
    test_reset_in_memwr();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port cond, input, 4 bits: decoded condition field, instruction bits 31:28.
REQ-004 SHALL have port op, input, 2 bits: decoded class, instruction bits 27:26 (00 data-proc, 01 load/store, 10 branch).
REQ-005 SHALL have port i_bit, input, 1 bit: immediate flag, bit 25.
REQ-006 SHALL have port opcode, input, 4 bits: data-proc opcode, bits 24:21.
REQ-007 SHALL have port s_bit, input, 1 bit: set-flags, bit 20.
REQ-008 SHALL have ports u_bit, l1_bit and l2_bit, inputs, 1 bit each: up/down (bit 23), load/store (bit 20) and branch-link (bit 24).
REQ-009 SHALL have port alu_nzcv, input, 4 bits: ALU result flags.
REQ-010 SHALL have port mem_ready, input, 1 bit: memory access complete.
REQ-011 SHALL have outputs pc_write, ir_write, reg_write, mem_read, mem_write, flags_write and link_sel, 1 bit each: datapath strobes; link_sel selects r14 as write destination.
REQ-012 SHALL have outputs adr_src, 1 bit (0 = PC, 1 = ALU result), and alu_src_b, 1 bit (0 = register, 1 = immediate/offset).
REQ-013 SHALL have outputs alu_ctrl, 4 bits (ALU opcode), flags_q, 4 bits (stored NZCV), and state_o, 4 bits (current state).

Function
REQ-014 SHALL implement FSM states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
REQ-015 In FETCH, SHALL assert mem_read with adr_src=0 and, in the completing cycle, ir_write and pc_write for one cycle, then go to DECODE.
REQ-016 In DECODE, SHALL evaluate cond against flags_q: EQ/NE, CS/CC, MI/PL, VS/VC, HI/LS, GE/LT, GT/LE, AL=1110 always passes, 1111 never passes.
REQ-017 On failed condition in DECODE, or op=11, SHALL return to FETCH with no strobes asserted.
REQ-018 On passed condition in DECODE, SHALL branch: op=00 with i_bit=0 -> EXECR; op=00 with i_bit=1 -> EXECI; op=01 -> MEMADR; op=10 -> BRANCH.
REQ-019 EXECR/EXECI SHALL drive alu_ctrl=opcode and alu_src_b=0 (EXECR) or 1 (EXECI), then go to ALUWB.
REQ-020 ALUWB SHALL assert reg_write unless opcode[3:2]=10 (TST/TEQ/CMP/CMN) and SHALL assert flags_write when s_bit=1 (always for opcode[3:2]=10); then go to FETCH.
REQ-021 flags_q SHALL load alu_nzcv on the clock edge where flags_write=1 and hold its value otherwise.
REQ-022 MEMADR SHALL drive alu_ctrl=0100 (ADD) when u_bit=1, else 0010 (SUB), with alu_src_b=1, then go to MEMRD if l1_bit=1, else to MEMWR.
REQ-023 MEMRD SHALL assert mem_read with adr_src=1 and go to MEMWB on completion; MEMWB SHALL assert reg_write and go to FETCH.
REQ-024 MEMWR SHALL assert mem_write with adr_src=1 and go to FETCH on completion.
REQ-025 BRANCH SHALL assert pc_write with alu_ctrl=0100 and alu_src_b=1; if l2_bit=1, SHALL also assert reg_write with link_sel=1; then go to FETCH.
REQ-026 All strobes SHALL be Moore outputs decoded from state and fields, never asserted in states not listed for them; alu_ctrl SHALL default to 0100.

Reset
REQ-027 When rst_n=0 at a clock edge, SHALL enter FETCH, clear flags_q to 0000 and deassert all strobes in the following cycle, abandoning any in-progress access.

Configuration
REQ-028 With MULTICYCLE_CTRL_MEM_WAIT_EN defined, FETCH, MEMRD and MEMWR SHALL hold state and their strobes until mem_ready=1; ir_write/pc_write in FETCH SHALL fire only in the mem_ready=1 cycle.
REQ-029 Without MULTICYCLE_CTRL_MEM_WAIT_EN, every memory state SHALL complete in one cycle and mem_ready SHALL be ignored.

Structure
REQ-030 A shared package ctrl_pkg SHALL hold the state enum, condition-code constants and ALU opcode constants (ADD=0100, SUB=0010).
REQ-031 Condition evaluation SHALL be a combinational sub-module cond_check (inputs cond and flags; output pass).

Verification
REQ-032 ADD r1,r2,r3 (cond=1110, op=00, i_bit=0, opcode=0100, s_bit=1), alu_nzcv=0100 -> state sequence 0,1,6,8,0; reg_write and flags_write in state 8; flags_q=0100 afterward.
REQ-033 BEQ with flags_q Z=0 -> state sequence 0,1,0; no pc_write after FETCH; with Z=1 -> 0,1,9,0, pc_write in state 9.
REQ-034 LDR with l1_bit=1 and u_bit=0, MEM_WAIT_EN defined, mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles with mem_read high; alu_ctrl=0010 in MEMADR; reg_write in MEMWB.
REQ-035 CMP (opcode=1010, s_bit=0) -> flags_write=1 and reg_write=0 in ALUWB.
REQ-036 BL (l2_bit=1) -> reg_write=1 and link_sel=1 in BRANCH; rst_n=0 asserted while in MEMWR -> FETCH next cycle, flags_q=0000, mem_write=0.
